// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter and sequencer that shares one uart_tx byte transmitter
// between NUM_REQ byte-producing requesters. One requester is granted at a
// time. Its byte is registered onto tx_data and a one-cycle tx_start is
// issued. The arbiter then follows tx_busy through the frame and optionally
// idles GAP_CYCLES cycles before it arbitrates again.
//
// Ports:
//   clk       in   1            rising-edge system clock
//   rst       in   1            synchronous active-high reset
//   req       in   NUM_REQ      per-requester request
//   req_data  in   8*NUM_REQ    byte of requester i on [8i+7:8i]
//   ack       out  NUM_REQ      one-cycle accept pulse, one-hot, with tx_start
//   tx_data   out  8            registered byte, held until the next grant
//   tx_start  out  1            one-cycle start pulse to uart_tx
//   tx_busy   in   1            uart_tx busy while shifting a frame
//   grant_id  out  IDW          index of the last granted requester
//   active    out  1            high whenever the sequencer is not idle
//
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.

module uart_tx_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int GAP_CYCLES = 0,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active
);

    // Gap counter holds values up to GAP_CYCLES-1 without wrapping.
    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [IDW-1:0]       last_reg, last_next;
    logic [CW-1:0]        gap_cnt_reg, gap_cnt_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic                 tx_start_reg, tx_start_next;
    logic [7:0]           tx_data_reg, tx_data_next;
    logic [IDW-1:0]       grant_id_reg, grant_id_next;

    logic [7:0]           req_bytes [NUM_REQ];
    logic [IDW-1:0]       winner;
    logic                 found;
    logic                 grant;

    // Split the flat data bus into one byte per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotating priority: scan upward from last_reg+1, wrapping at NUM_REQ-1.
    // The previously granted requester is looked at last.
    always_comb begin
        int cand;
        cand   = 0;
        winner = '0;
        found  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_reg) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    // Requests are only looked at in IDLE, and never while a frame is still
    // being shifted (e.g. one left running across a reset).
    assign grant = (state_reg == S_IDLE) && found && !tx_busy;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            last_reg     <= IDW'(NUM_REQ - 1);
            gap_cnt_reg  <= '0;
            ack_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            grant_id_reg <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            gap_cnt_reg  <= gap_cnt_next;
            ack_reg      <= ack_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
            grant_id_reg <= grant_id_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant) begin
                    state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // uart_tx may take any number of cycles to raise busy.
                if (tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output / datapath logic: everything here feeds a register.
    always_comb begin
        last_next     = last_reg;
        ack_next      = '0;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_reg;
        grant_id_next = grant_id_reg;
        gap_cnt_next  = gap_cnt_reg;

        if (grant) begin
            last_next     = winner;
            ack_next      = NUM_REQ'(1) << winner;
            tx_start_next = 1'b1;
            tx_data_next  = req_bytes[winner];
            grant_id_next = winner;
        end

        // Load on the way into GAP, count down while in GAP.
        if (state_reg == S_WAIT_DONE && !tx_busy) begin
            gap_cnt_next = GAP_LOAD;
        end else if (state_reg == S_GAP && gap_cnt_reg != '0) begin
            gap_cnt_next = gap_cnt_reg - 1'b1;
        end
    end

    assign ack      = ack_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign grant_id = grant_id_reg;
    assign active   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Two instances run side by side, one with no
// gap and one with a 5-cycle gap. Each instance has its own requesters, a
// modelled uart_tx and a scoreboard. The reference model works in cycle
// arithmetic: after a grant at sample S, the arbiter can grant again at
// sample S + busy_delay + busy_len + 2 + GAP. The winner is the first
// requesting index after the previous winner, wrapping around.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } grant_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   phase  = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Round-robin pick from the rule: first set bit after 'last', wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        int       c;
        logic [1:0] ci;
        for (int off = 1; off <= NUM_REQ; off++) begin
            c  = (last + off) % NUM_REQ;
            ci = 2'(c);
            if (r[ci]) return c;
        end
        return -1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int GAP = (gi == 0) ? 0 : 5;

            logic [NUM_REQ-1:0]   req;
            logic [8*NUM_REQ-1:0] req_data;
            logic [NUM_REQ-1:0]   ack;
            logic [7:0]           tx_data;
            logic                 tx_start;
            logic                 tx_busy;
            logic [1:0]           grant_id;
            logic                 active;

            grant_t exp_q[$];
            int     act_lo;
            int     act_hi;

            uart_tx_arbiter #(
                .NUM_REQ   (NUM_REQ),
                .GAP_CYCLES(GAP)
            ) dut (
                .clk     (clk),
                .rst     (rst),
                .req     (req),
                .req_data(req_data),
                .ack     (ack),
                .tx_data (tx_data),
                .tx_start(tx_start),
                .tx_busy (tx_busy),
                .grant_id(grant_id),
                .active  (active)
            );

            // Stimulus + reference model. Runs on the falling edge and sets
            // the inputs for the next rising edge (sample index k).
            initial begin : stim
                int         k;
                logic [NUM_REQ-1:0] rv;
                logic [7:0] dv [NUM_REQ];
                int         granted;
                int         fs, fd, fb;
                bit         fvalid;
                int         last_id, free_at;
                int         prev_phase, step, wd_t, w;
                bit         bv;
                grant_t     e;

                rv = '0;
                for (int i = 0; i < NUM_REQ; i++) dv[i] = 8'($urandom);
                granted = -1;
                fs = 0; fd = 0; fb = 0; fvalid = 1'b0;
                last_id = NUM_REQ - 1;
                free_at = 0;
                prev_phase = -1; step = 0; wd_t = 0;
                act_lo = 1; act_hi = 0;
                req = '0; req_data = '0; tx_busy = 1'b0;

                forever begin
                    @(negedge clk);
                    k = cyc + 1;
                    if (phase != prev_phase) begin
                        step = 0;
                        prev_phase = phase;
                    end

                    // Requesters react to the grant made at the previous sample.
                    case (phase)
                        1: begin   // one byte from requester 2
                            if (granted == 2) step = 1;
                            rv = (step == 0) ? 4'b0100 : 4'b0000;
                            dv[2] = 8'hA5;
                        end
                        2: begin   // everybody, continuously
                            rv = 4'b1111;
                            if (granted >= 0) dv[granted] = 8'($urandom);
                        end
                        3: begin   // requester 1 only, continuously
                            rv = 4'b0010;
                            if (granted >= 0) dv[granted] = 8'($urandom);
                        end
                        4: begin   // random raise / withdraw / re-request
                            for (int i = 0; i < NUM_REQ; i++) begin
                                if (granted == i) begin
                                    if ($urandom_range(1, 0) == 1) begin
                                        rv[i] = 1'b1;
                                        dv[i] = 8'($urandom);
                                    end else begin
                                        rv[i] = 1'b0;
                                    end
                                end else if (rv[i]) begin
                                    if ($urandom_range(15, 0) == 0) rv[i] = 1'b0;
                                end else if ($urandom_range(3, 0) == 0) begin
                                    rv[i] = 1'b1;
                                    dv[i] = 8'($urandom);
                                end
                            end
                        end
                        5: begin   // requesters 0 and 3 across a mid-frame reset
                            rv = 4'b1001;
                            if (granted >= 0) dv[granted] = 8'($urandom);
                        end
                        6: begin   // requester 1 withdraws during a frame
                            if (step == 0 && granted == 0) begin step = 1; wd_t = k; end
                            if (step == 1 && k >= wd_t + 3) step = 2;
                            if (step == 2 && granted == 2) step = 3;
                            case (step)
                                0:       rv = 4'b0001;
                                1:       rv = 4'b0110;
                                2:       rv = 4'b0100;
                                default: rv = 4'b0000;
                            endcase
                            if (granted >= 0) dv[granted] = 8'($urandom);
                        end
                        default: rv = '0;
                    endcase

                    // Modelled uart_tx busy for this sample.
                    bv = fvalid && (k >= fs + 1 + fd) && (k <= fs + fd + fb);

                    granted = -1;
                    if (rst) begin
                        last_id = NUM_REQ - 1;
                        free_at = k + 1;
                        act_lo  = k;
                        act_hi  = k - 1;
                    end else if (k >= free_at && rv != '0 && !bv) begin
                        w = rr_pick(rv, last_id);
                        e.due  = k;
                        e.id   = w;
                        e.data = dv[w];
                        exp_q.push_back(e);
                        last_id = w;
                        granted = w;
                        case (phase)
                            4: begin
                                fd = int'($urandom_range(3, 1));
                                fb = int'($urandom_range(12, 1));
                            end
                            5:       begin fd = 1; fb = 20; end
                            default: begin fd = 1; fb = 10; end
                        endcase
                        fs      = k;
                        fvalid  = 1'b1;
                        free_at = k + fd + fb + 2 + GAP;
                        act_lo  = k;
                        act_hi  = k + fd + fb + GAP;
                    end

                    req = rv;
                    for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = dv[i];
                    tx_busy = bv;
                end
            end

            // Monitor: samples just after each rising edge.
            initial begin : mon
                grant_t     e;
                logic [7:0] exp_data;
                logic [1:0] exp_id;
                exp_data = 8'h00;
                exp_id   = 2'd0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (rst) begin
                        exp_data = 8'h00;
                        exp_id   = 2'd0;
                    end
                    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                        e = exp_q.pop_front();
                        check($sformatf("g%0d tx_start", gi), 32'(tx_start), 32'd1);
                        check($sformatf("g%0d ack", gi), 32'(ack), 32'(1 << e.id));
                        exp_data = e.data;
                        exp_id   = 2'(e.id);
                        $display("g%0d cycle %0d: grant id=%0d data=%02h (got id=%0d data=%02h)",
                                 gi, cyc, e.id, e.data, grant_id, tx_data);
                    end else begin
                        check($sformatf("g%0d tx_start idle", gi), 32'(tx_start), 32'd0);
                        check($sformatf("g%0d ack idle", gi), 32'(ack), 32'd0);
                    end
                    check($sformatf("g%0d tx_data", gi), 32'(tx_data), 32'(exp_data));
                    check($sformatf("g%0d grant_id", gi), 32'(grant_id), 32'(exp_id));
                    check($sformatf("g%0d active", gi), 32'(active),
                          32'((cyc >= act_lo && cyc <= act_hi) ? 1 : 0));
                end
            end
        end
    endgenerate

    task automatic run_phase(input int p, input int n);
        phase = p;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin : seq
        int n;
        rst   = 1'b1;
        phase = 0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;

        run_phase(1, 30);
        run_phase(2, 100);
        run_phase(3, 60);
        run_phase(6, 60);
        run_phase(4, 1500);
        run_phase(0, 40);

        // Reset while the no-gap instance is mid-frame with busy high.
        phase = 5;
        n = 0;
        while (!g_inst[0].tx_busy && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("g0 frame before reset", 32'(n < 200), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #2;

        run_phase(0, 60);
        check("g0 grants outstanding", 32'(g_inst[0].exp_q.size()), 32'd0);
        check("g1 grants outstanding", 32'(g_inst[1].exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
